cipher_uart_tx: RTL

- Downstream consumer of the block cipher's per-clock encrypted byte stream.
- Buffers encrypted bytes in a small synchronous FIFO, then serialises them onto a UART line (8N1, LSB first) for off-chip capture.
- Provides flow status (ready/full/overflow) so the cipher top can gate or flag data loss.

---
 rtl/block_cipher_pkg.sv | 16 +
 rtl/cipher_sync_fifo.sv | 57 +++++
 rtl/cipher_uart_tx.sv | 117 +++++++++++
 3 files changed

// File: rtl/block_cipher_pkg.sv
// block_cipher_pkg: shared UART FSM state encoding and default bit timing.
// Contents:
//   uart_state_e      - 2-bit UART transmitter states IDLE/START/DATA/STOP
//   CLK_HZ, BAUD      - nominal system clock and line rate
//   DEF_CLKS_PER_BIT  - clocks per UART bit derived from CLK_HZ/BAUD (868)
package block_cipher_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_e;
    localparam int CLK_HZ           = 100_000_000;
    localparam int BAUD             = 115_200;
    localparam int DEF_CLKS_PER_BIT = CLK_HZ / BAUD;
endpackage

// File: rtl/cipher_sync_fifo.sv
// cipher_sync_fifo: synchronous FIFO with occupancy count.
// Ports:
//   clk, rst (async active-low)
//   push/wr_data - write request; ignored when full
//   pop/rd_data  - read request; rd_data always shows the head entry
//   count        - occupancy 0..DEPTH; full/empty derived from it
module cipher_sync_fifo #(
    parameter int DEPTH  = 16,
    parameter int WIDTH  = 8,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              pop,
    output logic [WIDTH-1:0]  rd_data,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    logic [WIDTH-1:0]  mem_q [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              do_push, do_pop;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        full     = count_q == (ADDR_W+1)'(DEPTH);
        empty    = count_q == '0;
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + ADDR_W'(do_push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(do_pop);
        count_d  = count_q + (ADDR_W+1)'(do_push) - (ADDR_W+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; pointer reset alone discards the contents.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
endmodule

// File: rtl/cipher_uart_tx.sv
// cipher_uart_tx: buffers cipher output bytes and sends them as 8N1 UART frames.
// Ports:
//   clk, rst (async active-low)
//   din/din_valid - byte stream from the cipher; din_ready = FIFO not full
//   tx            - registered serial line, idle high, LSB first
//   busy          - transmitter not idle
//   fifo_count    - FIFO occupancy 0..FIFO_DEPTH
//   overflow      - sticky flag: a byte arrived while the FIFO was full
module cipher_uart_tx
    import block_cipher_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int FIFO_DEPTH   = 16,
    parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        din,
    input  logic              din_valid,
    output logic              din_ready,
    output logic              tx,
    output logic              busy,
    output logic [ADDR_W:0]   fifo_count,
    output logic              overflow
);
    localparam int CNT_W = $clog2(CLKS_PER_BIT);

    uart_state_e      state_q, state_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic             fifo_full, fifo_empty, pop, bit_end;
    logic [7:0]       fifo_data;

    assign pop = (state_q == IDLE) && !fifo_empty;

    cipher_sync_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .WIDTH  (8),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (din_valid),
        .wr_data (din),
        .pop     (pop),
        .rd_data (fifo_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // tx_d always carries the level of the next bit period so the line
    // changes on the same edge as the state that owns it.
    always_comb begin
        state_d    = state_q;
        clk_cnt_d  = clk_cnt_q;
        bit_idx_d  = bit_idx_q;
        shift_d    = shift_q;
        tx_d       = tx_q;
        overflow_d = overflow_q | (din_valid & fifo_full);
        bit_end    = clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1);
        if (state_q != IDLE) clk_cnt_d = bit_end ? '0 : clk_cnt_q + 1'b1;
        case (state_q)
            IDLE: begin
                tx_d      = 1'b1;
                clk_cnt_d = '0;
                if (pop) begin
                    shift_d = fifo_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: if (bit_end) begin
                state_d   = DATA;
                bit_idx_d = '0;
                tx_d      = shift_q[0];
            end
            DATA: if (bit_end) begin
                shift_d   = shift_q >> 1;
                bit_idx_d = bit_idx_q + 1'b1;
                state_d   = (bit_idx_q == 3'd7) ? STOP : DATA;
                tx_d      = (bit_idx_q == 3'd7) ? 1'b1 : shift_q[1];
            end
            STOP: if (bit_end) begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            clk_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_cnt_q  <= clk_cnt_d;
            bit_idx_q  <= bit_idx_d;
            shift_q    <= shift_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = state_q != IDLE;
    assign din_ready = !fifo_full;
    assign overflow  = overflow_q;
endmodule
